// File: rtl/axi_sram_slave_if.sv
// AXI-lite style channel bundle between a requesting master and axi_sram_slave.
// The master drives addresses, write data and response readies; the slave drives the rest.
interface axi_sram_slave_if;
  logic [63:0] AW_ADDR;
  logic        AW_VALID;
  logic        AW_READY;
  logic [63:0] W_DATA;
  logic [7:0]  W_STRB;
  logic        W_VALID;
  logic        W_READY;
  logic        B_VALID;
  logic        B_READY;
  logic [63:0] AR_ADDR;
  logic        AR_VALID;
  logic        AR_READY;
  logic [63:0] R_DATA;
  logic        R_VALID;
  logic        R_READY;

  modport master (
    output AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    input  AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );

  modport slave (
    input  AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    output AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-port 64-bit SRAM slave serving one outstanding read or write at a time.
// Define SRAM_RAND_DELAY_EN to add 0-7 cycles of LFSR-driven latency per access.
module axi_sram_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_sram_slave_if.slave   bus,
  output logic [15:0]       err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [15:0]   err_q, err_d;
  logic [63:0]   mem [DEPTH];

  logic [63:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [CW-1:0] rd_load, wr_load;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign rd_load = CW'(RD_LAT - 1) + CW'(lfsr_q[2:0]);
  assign wr_load = CW'(WR_LAT - 1) + CW'(lfsr_q[2:0]);
`else
  assign rd_load = CW'(RD_LAT - 1);
  assign wr_load = CW'(WR_LAT - 1);
`endif

  // Decode always works on the latched address, wrapping below BASE_ADDR to a huge offset.
  assign off      = addr_q - BASE_ADDR;
  assign in_range = off < (64'(DEPTH) * 64'd8);
  assign idx      = off[AW+2:3];

  assign bus.AR_READY = (state_q == IDLE);
  assign bus.AW_READY = (state_q == IDLE) && !bus.AR_VALID;
  assign bus.W_READY  = (state_q == WR_DATA);
  assign bus.B_VALID  = (state_q == WR_RESP);
  assign bus.R_VALID  = (state_q == RD_RESP);
  assign bus.R_DATA   = rdata_q;
  assign err_cnt      = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.AR_VALID) begin
          addr_d  = bus.AR_ADDR;
          cnt_d   = rd_load;
          state_d = RD_WAIT;
        end else if (bus.AW_VALID) begin
          addr_d  = bus.AW_ADDR;
          state_d = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = in_range ? mem[idx] : 64'h0;
          if (!in_range) err_d = sat_inc(err_q);
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_RESP: if (bus.R_READY) state_d = IDLE;
      WR_DATA: begin
        if (bus.W_VALID) begin
          cnt_d = wr_load;
          if (!in_range) err_d = sat_inc(err_q);
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) state_d = WR_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      WR_RESP: if (bus.B_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset: contents survive rst_n, and writes commit on the W edge itself.
  always_ff @(posedge clk) begin
    if (state_q == WR_DATA && bus.W_VALID && in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.W_STRB[b]) mem[idx][8*b +: 8] <= bus.W_DATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: latency, strobes, arbitration, back-pressure,
// out-of-range handling and reset in the middle of a read.
module tb_axi_sram_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] err_cnt;
  int          vec = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  axi_sram_slave_if bus();

  axi_sram_slave dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int n;
    @(negedge clk);
    bus.AW_ADDR = a; bus.AW_VALID = 1'b1; #1;
    n = 0;
    while (!bus.AW_READY && n < 50) begin @(negedge clk); n++; end
    vec++;
    if (bus.AW_READY !== 1'b1) begin bad++; $display("FAIL aw_wait: AW_READY=%b required 1", bus.AW_READY); end
    @(negedge clk);
    bus.AW_VALID = 1'b0; bus.W_DATA = d; bus.W_STRB = s; bus.W_VALID = 1'b1; #1;
    n = 0;
    while (!bus.W_READY && n < 50) begin @(negedge clk); n++; end
    vec++;
    if (bus.W_READY !== 1'b1) begin bad++; $display("FAIL w_wait: W_READY=%b required 1", bus.W_READY); end
    @(negedge clk);
    bus.W_VALID = 1'b0; bus.B_READY = 1'b1;
    n = 0;
    while (!bus.B_VALID && n < 50) begin @(negedge clk); n++; end
    vec++;
    if (bus.B_VALID !== 1'b1) begin bad++; $display("FAIL b_wait: B_VALID=%b required 1", bus.B_VALID); end
    @(negedge clk);
    bus.B_READY = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] a, output logic [63:0] d);
    int n;
    @(negedge clk);
    bus.AR_ADDR = a; bus.AR_VALID = 1'b1; #1;
    n = 0;
    while (!bus.AR_READY && n < 50) begin @(negedge clk); n++; end
    vec++;
    if (bus.AR_READY !== 1'b1) begin bad++; $display("FAIL ar_wait: AR_READY=%b required 1", bus.AR_READY); end
    @(negedge clk);
    bus.AR_VALID = 1'b0; bus.R_READY = 1'b1;
    n = 0;
    while (!bus.R_VALID && n < 50) begin @(negedge clk); n++; end
    vec++;
    if (bus.R_VALID !== 1'b1) begin bad++; $display("FAIL r_wait: R_VALID=%b required 1", bus.R_VALID); end
    d = bus.R_DATA;
    @(negedge clk);
    bus.R_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vec++; if (bus.R_VALID !== 1'b0)  begin bad++; $display("FAIL rst_rvalid: got %b required 0", bus.R_VALID); end
    vec++; if (bus.B_VALID !== 1'b0)  begin bad++; $display("FAIL rst_bvalid: got %b required 0", bus.B_VALID); end
    vec++; if (bus.W_READY !== 1'b0)  begin bad++; $display("FAIL rst_wready: got %b required 0", bus.W_READY); end
    vec++; if (bus.AR_READY !== 1'b1) begin bad++; $display("FAIL rst_arready: got %b required 1", bus.AR_READY); end
    vec++; if (bus.AW_READY !== 1'b1) begin bad++; $display("FAIL rst_awready: got %b required 1", bus.AW_READY); end
    vec++; if (bus.R_DATA !== 64'h0)  begin bad++; $display("FAIL rst_rdata: got %h required 0", bus.R_DATA); end
    vec++; if (err_cnt !== 16'h0)     begin bad++; $display("FAIL rst_errcnt: got %h required 0", err_cnt); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.AW_ADDR = 64'h8000_0010; bus.AW_VALID = 1'b1; #1;
    vec++; if (bus.AW_READY !== 1'b1) begin bad++; $display("FAIL wr_awready: got %b required 1", bus.AW_READY); end
    @(negedge clk);
    bus.AW_VALID = 1'b0; bus.W_DATA = 64'h1122_3344_5566_7788; bus.W_STRB = 8'hFF; bus.W_VALID = 1'b1; #1;
    vec++; if (bus.W_READY !== 1'b1) begin bad++; $display("FAIL wr_wready: got %b required 1", bus.W_READY); end
    @(negedge clk);
    bus.W_VALID = 1'b0;
    vec++; if (bus.B_VALID !== 1'b0) begin bad++; $display("FAIL wr_bvalid_early: got %b required 0", bus.B_VALID); end
    @(negedge clk);
    vec++; if (bus.B_VALID !== 1'b1) begin bad++; $display("FAIL wr_bvalid_lat: got %b required 1", bus.B_VALID); end
    bus.B_READY = 1'b1;
    @(negedge clk);
    bus.B_READY = 1'b0;
    vec++; if (bus.B_VALID !== 1'b0) begin bad++; $display("FAIL wr_bvalid_drop: got %b required 0", bus.B_VALID); end
    @(negedge clk);
    bus.AR_ADDR = 64'h8000_0010; bus.AR_VALID = 1'b1; #1;
    vec++; if (bus.AR_READY !== 1'b1) begin bad++; $display("FAIL rd_arready: got %b required 1", bus.AR_READY); end
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    vec++; if (bus.R_VALID !== 1'b0) begin bad++; $display("FAIL rd_rvalid_t0: got %b required 0", bus.R_VALID); end
    @(negedge clk);
    vec++; if (bus.R_VALID !== 1'b0) begin bad++; $display("FAIL rd_rvalid_t1: got %b required 0", bus.R_VALID); end
    @(negedge clk);
    vec++; if (bus.R_VALID !== 1'b1) begin bad++; $display("FAIL rd_rvalid_lat: got %b required 1", bus.R_VALID); end
    vec++; if (bus.R_DATA !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL rd_data: got %h required 1122334455667788", bus.R_DATA); end
    bus.R_READY = 1'b1;
    @(negedge clk);
    bus.R_READY = 1'b0;
    vec++; if (bus.R_VALID !== 1'b0)  begin bad++; $display("FAIL rd_rvalid_drop: got %b required 0", bus.R_VALID); end
    vec++; if (bus.AR_READY !== 1'b1) begin bad++; $display("FAIL rd_idle: AR_READY=%b required 1", bus.AR_READY); end
  endtask

  task automatic test_partial_strobe();
    logic [63:0] d;
    axi_write(64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    axi_read(64'h8000_0010, d);
    vec++; if (d !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL strobe_data: got %h required 11223344aaaaaaaa", d); end
  endtask

  task automatic test_collision();
    logic [63:0] d;
    int n;
    @(negedge clk);
    bus.AR_ADDR = 64'h8000_0010; bus.AR_VALID = 1'b1;
    bus.AW_ADDR = 64'h8000_0020; bus.AW_VALID = 1'b1;
    bus.W_DATA = 64'hDEAD_BEEF_CAFE_F00D; bus.W_STRB = 8'hFF; bus.W_VALID = 1'b1; #1;
    vec++; if (bus.AR_READY !== 1'b1) begin bad++; $display("FAIL coll_arready: got %b required 1", bus.AR_READY); end
    vec++; if (bus.AW_READY !== 1'b0) begin bad++; $display("FAIL coll_awready: got %b required 0", bus.AW_READY); end
    @(negedge clk);
    bus.AR_VALID = 1'b0; bus.R_READY = 1'b1; #1;
    vec++; if (bus.AW_READY !== 1'b0) begin bad++; $display("FAIL coll_awready_busy: got %b required 0", bus.AW_READY); end
    vec++; if (bus.W_READY !== 1'b0)  begin bad++; $display("FAIL coll_wready_early: got %b required 0", bus.W_READY); end
    n = 0;
    while (!bus.R_VALID && n < 50) begin @(negedge clk); n++; end
    vec++; if (bus.R_DATA !== 64'h1122_3344_AAAA_AAAA || bus.R_VALID !== 1'b1) begin
      bad++; $display("FAIL coll_rdata: got valid=%b data=%h required 1/11223344aaaaaaaa", bus.R_VALID, bus.R_DATA);
    end
    @(negedge clk);
    bus.R_READY = 1'b0; #1;
    vec++; if (bus.AW_READY !== 1'b1) begin bad++; $display("FAIL coll_awready_after: got %b required 1", bus.AW_READY); end
    @(negedge clk);
    bus.AW_VALID = 1'b0;
    vec++; if (bus.W_READY !== 1'b1) begin bad++; $display("FAIL coll_wready: got %b required 1", bus.W_READY); end
    @(negedge clk);
    bus.W_VALID = 1'b0; bus.B_READY = 1'b1;
    n = 0;
    while (!bus.B_VALID && n < 50) begin @(negedge clk); n++; end
    vec++; if (bus.B_VALID !== 1'b1) begin bad++; $display("FAIL coll_bvalid: got %b required 1", bus.B_VALID); end
    @(negedge clk);
    bus.B_READY = 1'b0;
    axi_read(64'h8000_0020, d);
    vec++; if (d !== 64'hDEAD_BEEF_CAFE_F00D) begin bad++; $display("FAIL coll_wdata: got %h required deadbeefcafef00d", d); end
    axi_read(64'h8000_0010, d);
    vec++; if (d !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL coll_other: got %h required 11223344aaaaaaaa", d); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus.AR_ADDR = 64'h8000_0020; bus.AR_VALID = 1'b1; bus.R_READY = 1'b0;
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    n = 0;
    while (!bus.R_VALID && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      vec++; if (bus.R_VALID !== 1'b1 || bus.R_DATA !== 64'hDEAD_BEEF_CAFE_F00D) begin
        bad++; $display("FAIL bp_hold%0d: got valid=%b data=%h required 1/deadbeefcafef00d", i, bus.R_VALID, bus.R_DATA);
      end
      @(negedge clk);
    end
    bus.R_READY = 1'b1;
    @(negedge clk);
    bus.R_READY = 1'b0;
    vec++; if (bus.R_VALID !== 1'b0 || bus.AR_READY !== 1'b1) begin
      bad++; $display("FAIL bp_release: got R_VALID=%b AR_READY=%b required 0/1", bus.R_VALID, bus.AR_READY);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] d;
    axi_write(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    axi_read(64'h7FFF_FFF8, d);
    vec++; if (d !== 64'h0) begin bad++; $display("FAIL oor_rdata: got %h required 0", d); end
    axi_write(64'h8000_8000, 64'h5555_5555_5555_5555, 8'hFF);
    axi_read(64'h8000_0000, d);
    vec++; if (d !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL oor_dropped: got %h required 0123456789abcdef", d); end
    vec++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL oor_errcnt: got %0d required 2", err_cnt); end
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] d;
    @(negedge clk);
    bus.AR_ADDR = 64'h8000_0010; bus.AR_VALID = 1'b1;
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    rst_n = 1'b0; #1;
    vec++; if (bus.R_VALID !== 1'b0 || bus.AR_READY !== 1'b1) begin
      bad++; $display("FAIL mid_rst: got R_VALID=%b AR_READY=%b required 0/1", bus.R_VALID, bus.AR_READY);
    end
    vec++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_errcnt: got %0d required 0", err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++; if (bus.R_VALID !== 1'b0) begin bad++; $display("FAIL mid_rst_discard: got %b required 0", bus.R_VALID); end
    axi_read(64'h8000_0020, d);
    vec++; if (d !== 64'hDEAD_BEEF_CAFE_F00D) begin bad++; $display("FAIL mid_rst_mem0: got %h required deadbeefcafef00d", d); end
    axi_read(64'h8000_0010, d);
    vec++; if (d !== 64'h1122_3344_AAAA_AAAA) begin bad++; $display("FAIL mid_rst_mem1: got %h required 11223344aaaaaaaa", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t required finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.AW_ADDR = '0; bus.AW_VALID = 1'b0;
    bus.W_DATA = '0; bus.W_STRB = '0; bus.W_VALID = 1'b0;
    bus.B_READY = 1'b0;
    bus.AR_ADDR = '0; bus.AR_VALID = 1'b0;
    bus.R_READY = 1'b0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_collision();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

- AXI-lite style single-port SRAM slave model.
- Sits directly downstream of the two-master SRAM arbiter and terminates its slave channel. It serves instruction-fetch and load/store traffic from one memory array.
- It serialises transactions: at most one read or write is outstanding.
- It models fixed access latency and, optionally, randomised latency to stress the upstream handshakes.

## Interface
Parameters:
- BASE_ADDR, 64'h8000_0000: byte address mapped to word 0.
- DEPTH, 4096: number of 64-bit words; power of two.
- RD_LAT, 2: cycles from AR handshake to first R_VALID; ≥1.
- WR_LAT, 1: cycles from W handshake to B_VALID; ≥1.

Ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- AW_ADDR, in, 64: write address.
- AW_VALID, in, 1: write address valid.
- AW_READY, out, 1: write address ready.
- W_DATA, in, 64: write data.
- W_STRB, in, 8: byte strobes; bit i enables byte i.
- W_VALID, in, 1: write data valid.
- W_READY, out, 1: write data ready.
- B_VALID, out, 1: write response valid.
- B_READY, in, 1: write response ready.
- AR_ADDR, in, 64: read address.
- AR_VALID, in, 1: read address valid.
- AR_READY, out, 1: read address ready.
- R_DATA, out, 64: read data.
- R_VALID, out, 1: read data valid.
- R_READY, in, 1: read data ready.
- err_cnt, out, 16: saturating count of out-of-range accesses.

## Operation
State machine states: IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP.

IDLE:
- AR_READY = 1.
- AW_READY = ~AR_VALID, so reads win over writes when both are presented.
- AR handshake: latch AR_ADDR, load the counter with RD_LAT-1, go to RD_WAIT.
- AW handshake (with AR_VALID low): latch AW_ADDR, go to WR_DATA.

RD_WAIT:
- Decrement the counter each cycle.
- When the counter is 0, read the memory into the R_DATA register and go to RD_RESP.

RD_RESP:
- R_VALID = 1; R_DATA is held stable until R_READY.
- Handshake returns to IDLE.

WR_DATA:
- W_READY = 1.
- On W handshake, write the strobed bytes into memory on that edge, load the counter with WR_LAT-1, go to WR_WAIT.

WR_WAIT:
- Decrement the counter; when it is 0, go to WR_RESP.

WR_RESP:
- B_VALID = 1 until B_READY, then return to IDLE.

Address decode:
- off = addr − BASE_ADDR, using 64-bit wrapping subtraction.
- Word index = off[log2(DEPTH)+2:3]; addr[2:0] is ignored, and the full word is returned.
- An access is in range iff off < DEPTH*8.

Out-of-range accesses:
- Reads return 64'h0; writes are dropped.
- The handshake and latency are unchanged.
- err_cnt increments once per transaction and saturates at 16'hFFFF.

Combinational paths:
- AR_READY and AW_READY may depend combinationally on AR_VALID and state.
- No other output depends combinationally on an input.

## Timing
Reset:
- Reset is asynchronous and active-low.
- On reset: state = IDLE, counter = 0, R_DATA = 0, R_VALID = 0, B_VALID = 0, W_READY = 0, err_cnt = 0.
- AR_READY and AW_READY follow the IDLE equations immediately.
- Memory contents are not cleared.

Reset mid-operation:
- Any pending response is discarded.
- A write already committed at its W edge persists.

Latency:
- Read: AR handshake at edge t gives R_VALID high in the cycle after edge t+RD_LAT.
- Write: W handshake at edge t gives B_VALID high in the cycle after edge t+WR_LAT.

Back-pressure:
- R_VALID/R_DATA and B_VALID stay stable while READY is low. No timeout.
- Back-to-back requests: a request can be accepted in the cycle after a response handshake. Minimum read period is RD_LAT+2 cycles.
- A W_VALID presented before its AW handshake is not consumed until WR_DATA.
- Read-after-write to the same address returns the new data.

## Configuration
- SRAM_RAND_DELAY_EN defined:
  - A 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - On each AR or W handshake, the counter load becomes LAT−1 + LFSR[2:0], adding 0–7 cycles.
- SRAM_RAND_DELAY_EN undefined:
  - No LFSR is built; latency is exactly RD_LAT / WR_LAT.

## Test plan
- Reset, then write AW_ADDR=0x8000_0010, W_DATA=0x1122334455667788, W_STRB=0xFF, then read 0x8000_0010. Expect B_VALID 1 cycle after the W edge; R_DATA=0x1122334455667788 with R_VALID 2 cycles after the AR edge.
- Partial strobe: write 0xAAAA... with W_STRB=0x0F over the prior word. Read returns 0x11223344AAAAAAAA.
- Same-cycle AR_VALID and AW_VALID: expect AR accepted and AW_READY low. The write is accepted only after the R handshake; both complete with correct data.
- Back-pressure: hold R_READY low for 5 cycles. R_VALID and R_DATA are unchanged every cycle; the handshake then returns to IDLE with AR_READY=1.
- Read 0x7FFF_FFF8 and write 0x8000_8000 (DEPTH=4096). Expect read data 0, write dropped, err_cnt=2, handshakes normal.
- Assert rst_n low during RD_WAIT. Expect R_VALID=0 and state IDLE immediately. Previously written memory still reads back correctly after reset.
